// File: rtl/queue_rr_drain.sv
// Round-robin drain of NQ framed show-ahead queues onto one output port.
// A granted queue forwards one whole message (header plus payload) before priority rotates.
module queue_rr_drain #(
   parameter int NQ      = 4,
   parameter int LENBITS = 6
) (
   input  logic               clk,
   input  logic               rst,
   input  logic [NQ-1:0]      q_empty,
   input  logic [NQ*32-1:0]   q_dout,
   output logic [NQ-1:0]      q_rd_en,
   input  logic [NQ-1:0]      src_en,
   output logic [31:0]        out_data,
   output logic               out_valid,
   input  logic               out_ready,
   output logic               out_first,
   output logic               out_last,
   output logic [2:0]         out_src,
   output logic               busy
);
   typedef enum logic [1:0] {IDLE, HDR, PAY} state_t;

   state_t             state_q, state_d;
   logic [2:0]         grant_q, grant_d;
   logic [2:0]         last_grant_q, last_grant_d;
   logic [LENBITS-1:0] cnt_q, cnt_d;

   logic [7:0]         elig_ext;
   logic [7:0]         empty_ext;
   logic [31:0]        dout_arr [8];
   logic [2:0]         cand [NQ];
   logic [NQ-1:0]      hit;
   logic [2:0]         pick;
   logic               head_ok;
   logic               hs;
   logic [LENBITS-1:0] hdr_len;

   assign elig_ext  = 8'(~q_empty & src_en);
   assign empty_ext = 8'(q_empty);

   // Pad the head-word view to 8 entries so a 3-bit grant indexes it directly.
   for (genvar gi = 0; gi < 8; gi++) begin : g_dout
      if (gi < NQ) begin : g_real
         assign dout_arr[gi] = q_dout[32*gi +: 32];
      end else begin : g_pad
         assign dout_arr[gi] = '0;
      end
   end

   // cand[k] is the queue tried k+1 places after the last granted one.
   for (genvar gi = 0; gi < NQ; gi++) begin : g_cand
      assign cand[gi] = 3'((32'(last_grant_q) + gi + 1) % NQ);
      assign hit[gi]  = elig_ext[cand[gi]];
   end

   always_comb begin
      pick = cand[0];
      for (int k = NQ - 1; k >= 0; k--) begin
         if (hit[k]) begin
            pick = cand[k];
         end
      end
   end

   assign out_data = dout_arr[grant_q];
   assign hdr_len  = out_data[LENBITS-1:0];
   assign head_ok  = ~empty_ext[grant_q] & ~rst;
   assign hs       = out_valid & out_ready;
   assign out_src  = grant_q;
   assign busy     = (state_q != IDLE);

   for (genvar gi = 0; gi < NQ; gi++) begin : g_rd
      assign q_rd_en[gi] = hs & (grant_q == 3'(gi));
   end

   always_comb begin
      state_d      = state_q;
      grant_d      = grant_q;
      last_grant_d = last_grant_q;
      cnt_d        = cnt_q;
      out_valid    = 1'b0;
      out_first    = 1'b0;
      out_last     = 1'b0;
      case (state_q)
         IDLE: begin
            if (|elig_ext) begin
               grant_d = pick;
               state_d = HDR;
            end
         end
         HDR: begin
            out_valid = head_ok;
            out_first = ~rst;
            out_last  = ~rst & (hdr_len == '0);
            if (head_ok && out_ready) begin
               cnt_d        = hdr_len;
               last_grant_d = grant_q;
               state_d      = (hdr_len == '0) ? IDLE : PAY;
            end
         end
         PAY: begin
            out_valid = head_ok;
            out_last  = ~rst & (cnt_q == LENBITS'(1));
            if (head_ok && out_ready) begin
               cnt_d = cnt_q - LENBITS'(1);
               if (cnt_q == LENBITS'(1)) begin
                  state_d = IDLE;
               end
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= IDLE;
         grant_q      <= '0;
         last_grant_q <= 3'(NQ - 1);
         cnt_q        <= '0;
      end else begin
         state_q      <= state_d;
         grant_q      <= grant_d;
         last_grant_q <= last_grant_d;
         cnt_q        <= cnt_d;
      end
   end
endmodule

// File: tb/tb_queue_rr_drain.sv
// Bench for queue_rr_drain: behavioural queues feed the DUT and a message-level
// round-robin model predicts the forwarded word stream.
module tb_queue_rr_drain;
   localparam int NQ      = 4;
   localparam int LENBITS = 6;

   typedef struct {
      logic [31:0] d;
      logic        f;
      logic        l;
      int          s;
   } word_t;

   logic             clk;
   logic             rst;
   logic [NQ-1:0]    q_empty;
   logic [NQ*32-1:0] q_dout;
   logic [NQ-1:0]    q_rd_en;
   logic [NQ-1:0]    src_en;
   logic [31:0]      out_data;
   logic             out_valid;
   logic             out_ready;
   logic             out_first;
   logic             out_last;
   logic [2:0]       out_src;
   logic             busy;

   logic [31:0] fifo [NQ][$];
   logic [31:0] mq [NQ][$];
   word_t       exp_q[$];
   word_t       obs_q[$];
   int          obs_cyc[$];
   int          cyc;
   int          errors;
   int          checks;

   logic          s_valid, s_first, s_last, s_busy;
   logic [31:0]   s_data;
   logic [2:0]    s_src;
   logic [NQ-1:0] s_rd;

   queue_rr_drain #(.NQ(NQ), .LENBITS(LENBITS)) dut (
      .clk       (clk),
      .rst       (rst),
      .q_empty   (q_empty),
      .q_dout    (q_dout),
      .q_rd_en   (q_rd_en),
      .src_en    (src_en),
      .out_data  (out_data),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_first (out_first),
      .out_last  (out_last),
      .out_src   (out_src),
      .busy      (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog expired");
      $fatal(1, "watchdog");
   end

   task automatic refresh();
      for (int i = 0; i < NQ; i++) begin
         q_empty[i]         = (fifo[i].size() == 0);
         q_dout[32*i +: 32] = (fifo[i].size() != 0) ? fifo[i][0] : 32'hDEAD_BEEF;
      end
   endtask

   // One clock: apply queue heads, sample at negedge, pop what the DUT strobed.
   task automatic cycle();
      logic [NQ-1:0] exp_rd;
      word_t         w;
      refresh();
      @(negedge clk);
      s_valid = out_valid; s_first = out_first; s_last = out_last;
      s_busy  = busy;      s_data  = out_data;  s_src  = out_src;  s_rd = q_rd_en;
      if (!rst) begin
         exp_rd = (out_valid && out_ready) ? (4'b0001 << out_src) : 4'b0000;
         checks++;
         if (q_rd_en !== exp_rd) begin
            errors++;
            $display("FAIL rd_strobe cyc=%0d got=%b exp=%b", cyc, q_rd_en, exp_rd);
         end
         if (out_valid && out_ready) begin
            w.d = out_data; w.f = out_first; w.l = out_last; w.s = int'(out_src);
            obs_q.push_back(w);
            obs_cyc.push_back(cyc);
         end
         for (int i = 0; i < NQ; i++) begin
            if (q_rd_en[i]) begin
               if (fifo[i].size() != 0) void'(fifo[i].pop_front());
               else begin
                  errors++;
                  $display("FAIL pop_empty cyc=%0d queue=%0d got=popped exp=no_pop", cyc, i);
               end
            end
         end
      end
      @(posedge clk);
      #1;
      cyc++;
   endtask

   task automatic do_reset();
      for (int i = 0; i < NQ; i++) fifo[i].delete();
      rst = 1'b1;
      out_ready = 1'b1;
      cycle();
      cycle();
      rst = 1'b0;
      obs_q.delete(); obs_cyc.delete(); exp_q.delete();
      cyc = 0;
   endtask

   // Message-level model: rotate from the last served queue, emit whole messages.
   task automatic build_model(input logic [NQ-1:0] en);
      int          last, q, len;
      bit          found, go;
      logic [31:0] h;
      word_t       w;
      for (int i = 0; i < NQ; i++) mq[i] = fifo[i];
      last = NQ - 1;
      q = 0;
      go = 1'b1;
      while (go) begin
         found = 1'b0;
         for (int k = 1; k <= NQ && !found; k++) begin
            q = (last + k) % NQ;
            if (en[q] && mq[q].size() > 0) found = 1'b1;
         end
         if (!found) go = 1'b0;
         else begin
            h = mq[q].pop_front();
            len = int'(h[LENBITS-1:0]);
            w.d = h; w.f = 1'b1; w.l = (len == 0); w.s = q;
            exp_q.push_back(w);
            for (int j = 0; j < len; j++) begin
               w.d = mq[q].pop_front(); w.f = 1'b0; w.l = (j == len - 1); w.s = q;
               exp_q.push_back(w);
            end
            last = q;
         end
      end
   endtask

   task automatic run_until(input int budget, input bit rnd_ready);
      int c = 0;
      while (obs_q.size() < exp_q.size() && c < budget) begin
         out_ready = rnd_ready ? ($urandom_range(0, 9) < 7) : 1'b1;
         cycle();
         c++;
      end
      checks++;
      if (obs_q.size() < exp_q.size()) begin
         errors++;
         $display("FAIL timeout got=%0d words exp=%0d words", obs_q.size(), exp_q.size());
      end
      out_ready = 1'b1;
      for (int k = 0; k < 6; k++) cycle();
   endtask

   task automatic compare_stream(input string name);
      int n;
      checks++;
      if (obs_q.size() != exp_q.size()) begin
         errors++;
         $display("FAIL %s word_count got=%0d exp=%0d", name, obs_q.size(), exp_q.size());
      end
      n = (obs_q.size() < exp_q.size()) ? obs_q.size() : exp_q.size();
      for (int i = 0; i < n; i++) begin
         checks++;
         if (obs_q[i].d !== exp_q[i].d || obs_q[i].f !== exp_q[i].f ||
             obs_q[i].l !== exp_q[i].l || obs_q[i].s != exp_q[i].s) begin
            errors++;
            $display("FAIL %s word[%0d] got d=%h f=%b l=%b s=%0d exp d=%h f=%b l=%b s=%0d",
                     name, i, obs_q[i].d, obs_q[i].f, obs_q[i].l, obs_q[i].s,
                     exp_q[i].d, exp_q[i].f, exp_q[i].l, exp_q[i].s);
         end
      end
      $display("%s: %0d words observed, %0d expected", name, obs_q.size(), exp_q.size());
   endtask

   task automatic test_reset();
      for (int i = 0; i < NQ; i++) fifo[i].delete();
      fifo[0].push_back(32'h0000_0000);
      src_en = 4'hF; out_ready = 1'b1; rst = 1'b1;
      cycle();
      cycle();
      checks += 6;
      if (s_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got=%b exp=0", s_valid); end
      if (s_rd !== 4'b0000) begin errors++; $display("FAIL reset_rd got=%b exp=0000", s_rd); end
      if (s_busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b exp=0", s_busy); end
      if (s_src !== 3'd0) begin errors++; $display("FAIL reset_src got=%0d exp=0", s_src); end
      if (s_first !== 1'b0) begin errors++; $display("FAIL reset_first got=%b exp=0", s_first); end
      if (s_last !== 1'b0) begin errors++; $display("FAIL reset_last got=%b exp=0", s_last); end
      rst = 1'b0;
      cycle();
      checks++;
      if (s_valid !== 1'b0 || s_busy !== 1'b0) begin
         errors++; $display("FAIL arb_cycle got valid=%b busy=%b exp valid=0 busy=0", s_valid, s_busy);
      end
      cycle();
      checks++;
      if (s_valid !== 1'b1 || s_src !== 3'd0 || s_first !== 1'b1 || s_last !== 1'b1) begin
         errors++;
         $display("FAIL arb_latency got v=%b src=%0d f=%b l=%b exp v=1 src=0 f=1 l=1",
                  s_valid, s_src, s_first, s_last);
      end
      $display("test_reset done");
   endtask

   task automatic test_single();
      logic exp_v, exp_b;
      do_reset();
      src_en = 4'hF; out_ready = 1'b1;
      fifo[0] = '{32'h0000_0003, $urandom, $urandom, $urandom};
      build_model(4'hF);
      for (int c = 0; c < 7; c++) begin
         cycle();
         exp_v = (c >= 1 && c <= 4);
         exp_b = (c >= 1 && c <= 4);
         checks += 3;
         if (s_valid !== exp_v) begin errors++; $display("FAIL single_valid c=%0d got=%b exp=%b", c, s_valid, exp_v); end
         if (s_rd !== (exp_v ? 4'b0001 : 4'b0000)) begin errors++; $display("FAIL single_rd c=%0d got=%b exp_valid=%b", c, s_rd, exp_v); end
         if (s_busy !== exp_b) begin errors++; $display("FAIL single_busy c=%0d got=%b exp=%b", c, s_busy, exp_b); end
      end
      compare_stream("single");
   endtask

   task automatic test_fairness();
      logic [31:0] h;
      do_reset();
      src_en = 4'hF;
      for (int i = 0; i < NQ; i++) begin
         h = 32'(i) << 8;
         fifo[i] = '{h, h};
      end
      build_model(4'hF);
      run_until(200, 1'b0);
      compare_stream("fairness");
      for (int i = 0; i + 1 < obs_cyc.size(); i++) begin
         checks++;
         if (obs_cyc[i+1] - obs_cyc[i] != 2) begin
            errors++;
            $display("FAIL fair_gap idx=%0d got=%0d exp=2", i, obs_cyc[i+1] - obs_cyc[i]);
         end
      end
   endtask

   task automatic test_backpressure();
      logic [31:0] p0;
      do_reset();
      src_en = 4'hF;
      p0 = $urandom;
      fifo[2] = '{($urandom & 32'hFFFF_FFC0) | 32'h2, p0, $urandom};
      build_model(4'hF);
      for (int c = 0; c < 10; c++) begin
         out_ready = !(c >= 2 && c <= 4);
         cycle();
         if (c >= 2 && c <= 4) begin
            checks++;
            if (s_valid !== 1'b1 || s_data !== p0 || s_rd !== 4'b0000) begin
               errors++;
               $display("FAIL stall c=%0d got v=%b d=%h rd=%b exp v=1 d=%h rd=0000",
                        c, s_valid, s_data, s_rd, p0);
            end
         end
      end
      compare_stream("backpressure");
   endtask

   task automatic test_empty_mid();
      logic [31:0] x1, x2;
      do_reset();
      src_en = 4'hF; out_ready = 1'b1;
      fifo[1] = '{32'h0000_0003, $urandom, $urandom, $urandom};
      fifo[3] = '{32'h0000_0300};
      build_model(4'hF);
      x2 = fifo[1].pop_back();
      x1 = fifo[1].pop_back();
      for (int c = 0; c < 8; c++) begin
         cycle();
         if (c >= 3) begin
            checks++;
            if (s_valid !== 1'b0 || s_src !== 3'd1 || s_busy !== 1'b1 || fifo[3].size() != 1) begin
               errors++;
               $display("FAIL starve c=%0d got v=%b src=%0d busy=%b q3=%0d exp v=0 src=1 busy=1 q3=1",
                        c, s_valid, s_src, s_busy, fifo[3].size());
            end
         end
      end
      fifo[1].push_back(x1);
      fifo[1].push_back(x2);
      run_until(100, 1'b0);
      compare_stream("empty_mid");
   endtask

   task automatic test_mask_zero();
      do_reset();
      src_en = 4'b1110;
      fifo[0] = '{32'h0000_0001, $urandom};
      fifo[1] = '{32'h0000_0040};
      build_model(4'b1110);
      run_until(100, 1'b0);
      compare_stream("mask_zero");
      checks += 2;
      if (fifo[0].size() != 2) begin errors++; $display("FAIL masked_q0 got=%0d words exp=2", fifo[0].size()); end
      if (s_busy !== 1'b0) begin errors++; $display("FAIL mask_idle_busy got=%b exp=0", s_busy); end
   endtask

   task automatic test_reset_mid();
      do_reset();
      src_en = 4'hF; out_ready = 1'b1;
      fifo[0] = '{32'h0000_0005, $urandom, $urandom,
                  $urandom << 6, $urandom << 6, $urandom << 6};
      fifo[1] = '{32'h0000_0100};
      for (int c = 0; c < 4; c++) cycle();
      rst = 1'b1;
      cycle();
      rst = 1'b0;
      checks++;
      if (fifo[0].size() != 3) begin errors++; $display("FAIL rst_left got=%0d words exp=3", fifo[0].size()); end
      obs_q.delete(); obs_cyc.delete(); exp_q.delete();
      build_model(4'hF);
      cycle();
      checks++;
      if (s_valid !== 1'b0 || s_busy !== 1'b0 || s_rd !== 4'b0000) begin
         errors++;
         $display("FAIL after_rst got v=%b busy=%b rd=%b exp v=0 busy=0 rd=0000", s_valid, s_busy, s_rd);
      end
      run_until(100, 1'b0);
      compare_stream("reset_mid");
   endtask

   task automatic test_random();
      logic [NQ-1:0] en;
      int            orig [NQ];
      int            nmsg, len;
      for (int it = 0; it < 4; it++) begin
         do_reset();
         en = 4'($urandom_range(1, 15));
         src_en = en;
         for (int i = 0; i < NQ; i++) begin
            nmsg = $urandom_range(0, 3);
            for (int m = 0; m < nmsg; m++) begin
               len = $urandom_range(0, 6);
               fifo[i].push_back(($urandom & 32'hFFFF_FFC0) | 32'(len));
               for (int j = 0; j < len; j++) fifo[i].push_back($urandom);
            end
            orig[i] = fifo[i].size();
         end
         build_model(en);
         run_until(2000, 1'b1);
         compare_stream("random");
         for (int i = 0; i < NQ; i++) begin
            if (!en[i]) begin
               checks++;
               if (fifo[i].size() != orig[i]) begin
                  errors++;
                  $display("FAIL random_mask q=%0d got=%0d words exp=%0d", i, fifo[i].size(), orig[i]);
               end
            end
         end
      end
   endtask

   initial begin
      errors = 0; checks = 0; cyc = 0;
      rst = 1'b1; out_ready = 1'b0; src_en = '0;
      q_empty = '1; q_dout = '0;
      test_reset();
      test_single();
      test_fairness();
      test_backpressure();
      test_empty_mid();
      test_mask_zero();
      test_reset_mid();
      test_random();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
